featuremap_pad_writer: RTL and testbench
========================================

// Module: featuremap_pad_writer
// PURPOSE
//   Write side of the per-channel featuremap FIFOs read by the conv2D featuremap blocks.
//   Takes the raster stream of one channel (WIDTH x HEIGHT words) from the previous layer.
//   Emits the zero-padded (WIDTH+2) x (HEIGHT+2) frame into one channel FIFO, in raster order.
//   Uses a wrreq/fifo_full handshake; stalls upstream through in_ready.
// PARAMETERS
//   DATA_WIDTH  32         word width (IEEE-754 single)
//   WIDTH       56         unpadded columns per row
//   HEIGHT      56         unpadded rows per frame
//   PAD_VALUE   32'h0      word written at every border position (+0.0)
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous, active-low reset
//   valid_in   in   1           upstream word valid
//   data_in    in   DATA_WIDTH  upstream word, raster order
//   in_ready   out  1           block accepts data_in this cycle
//   fifo_full  in   1           downstream FIFO full
//   wrreq      out  1           FIFO write strobe, one word per cycle
//   data_out   out  DATA_WIDTH  word written when wrreq=1
//   frame_done out  1           1-cycle pulse on the last padded word of a frame
// BEHAVIOUR
//   Reset (rst=0, async): row=0, col=0, skid buffer emptied.
//     in_ready=0 while in reset; it rises to 1 on the first clk after release.
//     wrreq=0, data_out=0, frame_done=0.
//   Input buffer: 2-entry register FIFO.
//     in_ready = (count<2), decoded from registered count.
//     Push when valid_in & in_ready.
//     Push and pop in the same cycle: count unchanged, order preserved.
//   Counters: col 0..WIDTH+1; row 0..HEIGHT+1.
//     Both advance only on a cycle where wrreq=1.
//     col wraps to 0 and increments row; row wraps to 0 after HEIGHT+1.
//     A new frame starts with no idle cycle.
//   Position classes:
//     interior = row in [1,HEIGHT] and col in [1,WIDTH]; all others are border.
//   FSM (state = row/col class): PAD_TOP, PAD_LEFT, DATA, PAD_RIGHT, PAD_BOTTOM.
//     PAD_TOP: row 0.
//     PAD_LEFT / DATA / PAD_RIGHT: rows 1..HEIGHT.
//     PAD_BOTTOM: row HEIGHT+1, then back to PAD_TOP.
//   wrreq (combinational): ~fifo_full & (border | (DATA & count!=0)).
//     data_out = PAD_VALUE on border, buffer head in DATA; a DATA write pops the head.
//   Latency: a word accepted in cycle N is written no earlier than cycle N+1.
//   Border words need no input; they are written back-to-back while fifo_full=0.
//   fifo_full=1 -> wrreq=0. Counters, FSM and buffer contents hold.
//     in_ready still follows count.
//   Empty buffer in DATA -> wrreq=0 and the position holds (bubble, no pad inserted).
//   Input beyond HEIGHT*WIDTH words stays buffered for the next frame; nothing is dropped.
//   frame_done=1 exactly in the cycle with wrreq=1 at row=HEIGHT+1, col=WIDTH+1.
//   Words per frame: (WIDTH+2)*(HEIGHT+2); 3364 at the defaults.
// CONFIGURATION
//   FEATUREMAP_PAD_RELU_EN
//     Defined: ReLU on the interior path. Head with sign bit=1 is written as 0; else unchanged.
//     Border words are always PAD_VALUE.
//     Undefined: interior words are written bit-exact; no ReLU logic is generated.
// TESTING (WIDTH=4, HEIGHT=4 unless stated)
//   Basic frame: stream d0..d15 continuously, fifo_full=0.
//     -> 36 writes; writes 0-6 are 0; write 7=d0, write 10=d3, writes 11-12 are 0.
//     -> write 35=0 with frame_done=1.
//   Back-pressure: fifo_full=1 for 10 cycles mid-row.
//     -> wrreq=0 for those 10 cycles; the write sequence is identical to basic frame.
//   Upstream gap: valid_in=0 for 5 cycles after d5.
//     -> exactly 5 bubble cycles at the d6 position; no extra 0 word; total writes = 36.
//   Buffer full: fifo_full=1 with valid_in=1 held.
//     -> two words accepted, then in_ready=0; after fifo_full=0 no word is lost or duplicated.
//   Reset mid-frame: rst=0 after write 20.
//     -> wrreq=0, data_out=0 at once; next frame restarts at row 0, col 0 (7 leading zeros).
//   RELU_EN: d0=32'hBF800000, d1=32'h3F800000.
//     -> with the macro, writes 7 and 8 are 0 and 3F800000.
//     -> without it, writes 7 and 8 are BF800000 and 3F800000.

Source files
------------

// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer
// Write side of one per-channel featuremap FIFO. The block takes a WIDTH x HEIGHT
// raster stream and emits a zero-bordered (WIDTH+2) x (HEIGHT+2) frame in raster
// order. Upstream is decoupled through a 2-entry register FIFO.
// Optional feature: define FEATUREMAP_PAD_RELU_EN to clamp negative interior words
// to zero. Border words are always PAD_VALUE.
module featuremap_pad_writer #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           WIDTH      = 56,
  parameter int unsigned           HEIGHT     = 56,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int unsigned COL_W = $clog2(WIDTH + 2);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 2);

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH + 1);
  localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT + 1);
  localparam logic [ROW_W-1:0] ROW_DATA_LAST = ROW_W'(HEIGHT);

  typedef enum logic [2:0] {
    PAD_TOP,
    PAD_LEFT,
    DATA,
    PAD_RIGHT,
    PAD_BOTTOM
  } state_e;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic                    run_q;
  logic [DATA_WIDTH-1:0]   mem_q [2];
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    push;
  logic                    pop;
  logic                    is_data;
  logic [DATA_WIDTH-1:0]   head;
  logic [DATA_WIDTH-1:0]   interior_word;

  // Handshake and write decode; run_q keeps everything quiet until the first clock after reset.
  assign in_ready   = run_q & (count_q != 2'd2);
  assign push       = valid_in & in_ready;
  assign is_data    = (state_q == DATA);
  assign head       = mem_q[rd_ptr_q];
  assign wrreq      = run_q & ~fifo_full & (~is_data | (count_q != 2'd0));
  assign pop        = wrreq & is_data;
  assign frame_done = wrreq & (state_q == PAD_BOTTOM) & (col_q == COL_LAST);

`ifdef FEATUREMAP_PAD_RELU_EN
  assign interior_word = head[DATA_WIDTH-1] ? '0 : head;
`else
  assign interior_word = head;
`endif

  assign data_out = !run_q ? '0 : (is_data ? interior_word : PAD_VALUE);

  // State, position counters, buffer pointers and the run flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PAD_TOP;
      row_q    <= '0;
      col_q    <= '0;
      run_q    <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      run_q    <= 1'b1;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Position advance and row/column class transitions, only on a written word.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (wrreq) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      unique case (state_q)
        PAD_TOP:    if (col_q == COL_LAST) state_d = PAD_LEFT;
        PAD_LEFT:   state_d = DATA;
        DATA:       if (col_q == COL_DATA_LAST) state_d = PAD_RIGHT;
        PAD_RIGHT:  state_d = (row_q == ROW_DATA_LAST) ? PAD_BOTTOM : PAD_LEFT;
        PAD_BOTTOM: if (col_q == COL_LAST) state_d = PAD_TOP;
        default:    state_d = PAD_TOP;
      endcase
    end
  end

  // Input buffer occupancy and pointers; simultaneous push and pop keeps count.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Bench for featuremap_pad_writer at WIDTH=4, HEIGHT=4. A reference model tracks the
// padded-frame position index and a queue of accepted words; every cycle it predicts
// in_ready, wrreq, frame_done and the written word.
module tb_featuremap_pad_writer;

  localparam int unsigned TW    = 4;
  localparam int unsigned TH    = 4;
  localparam int          FRAME = (TW + 2) * (TH + 2);

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        in_ready;
  logic        fifo_full;
  logic        wrreq;
  logic [31:0] data_out;
  logic        frame_done;

  featuremap_pad_writer #(
    .DATA_WIDTH(32),
    .WIDTH     (TW),
    .HEIGHT    (TH),
    .PAD_VALUE (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .wrreq     (wrreq),
    .data_out  (data_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;

  // reference model state
  logic [31:0] m_q[$];
  int          m_pos;
  bit          m_run;
  int          m_frames;
  bit          m_acc;
  logic [31:0] wlog [FRAME];
  int          wr_actual;

  // stimulus source
  logic [31:0] src[$];
  int          src_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int p);
    int r;
    int c;
    r = p / (TW + 2);
    c = p % (TW + 2);
    return !(r >= 1 && r <= TH && c >= 1 && c <= TW);
  endfunction

  function automatic logic [31:0] interior(input logic [31:0] w);
`ifdef FEATUREMAP_PAD_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  // Compare DUT outputs with the model, then advance the model across the coming edge.
  task automatic model_cycle();
    bit          exp_ir;
    bit          exp_wr;
    bit          brd;
    logic [31:0] exp_d;
    if (!rst) begin
      m_q.delete();
      m_pos = 0;
      m_run = 1'b0;
    end
    brd    = is_border(m_pos);
    exp_ir = m_run && (m_q.size() < 2);
    exp_wr = m_run && !fifo_full && (brd || m_q.size() > 0);
    check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
    check_eq("wrreq", 32'(wrreq), 32'(exp_wr));
    check_eq("frame_done", 32'(frame_done), 32'(exp_wr && m_pos == FRAME - 1));
    if (!rst) check_eq("reset_data_out", data_out, 32'h0);
    if (wrreq === 1'b1) wr_actual++;
    if (exp_wr) begin
      exp_d = brd ? 32'h0 : interior(m_q[0]);
      check_eq("data_out", data_out, exp_d);
      wlog[m_pos] = data_out;
      if (!brd) void'(m_q.pop_front());
      if (m_pos == FRAME - 1) m_frames++;
      m_pos = (m_pos + 1) % FRAME;
    end
    m_acc = valid_in && exp_ir;
    if (m_acc) m_q.push_back(data_in);
    if (rst) m_run = 1'b1;
  endtask

  task automatic tick(input logic v, input logic [31:0] d, input logic ff, input logic r);
    @(negedge clk);
    rst       = r;
    valid_in  = v;
    data_in   = d;
    fifo_full = ff;
    #1;
    model_cycle();
  endtask

  task automatic step(input bit v_en, input bit ff, input bit r = 1'b1);
    logic        v;
    logic [31:0] d;
    v = v_en && (src_i < src.size());
    d = v ? src[src_i] : $urandom;
    tick(v, d, ff, r);
    if (m_acc) src_i++;
  endtask

  task automatic load_frame(input logic [31:0] base, input bit rnd);
    src.delete();
    src_i = 0;
    for (int i = 0; i < TW * TH; i++) src.push_back(rnd ? 32'($urandom) : base + 32'(i));
    wr_actual = 0;
  endtask

  task automatic finish_frame(input string tag, input int ffprob, input int vprob);
    int target;
    int n;
    target = m_frames + 1;
    n = 0;
    while (m_frames < target && n < 600) begin
      step($urandom_range(99) < vprob, $urandom_range(99) < ffprob);
      n++;
    end
    check_eq({tag, "_frame_end"}, 32'(m_frames), 32'(target));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_pos     = 0;
    m_run     = 1'b0;
    m_frames  = 0;
    wr_actual = 0;
    src_i     = 0;
    valid_in  = 1'b0;
    data_in   = '0;
    fifo_full = 1'b0;
    rst       = 1'b1;
    #2 rst    = 1'b0;

    // reset hold, then release
    for (int i = 0; i < 3; i++) tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_eq("reset_in_ready", 32'(in_ready), 32'h0);
    check_eq("reset_wrreq", 32'(wrreq), 32'h0);

    // basic frame, continuous stream
    load_frame(32'h1000_0000, 1'b0);
    finish_frame("basic", 0, 100);
    check_eq("basic_writes", 32'(wr_actual), 32'(FRAME));
    for (int i = 0; i < 7; i++) check_eq("basic_lead_zero", wlog[i], 32'h0);
    check_eq("basic_w7", wlog[7], 32'h1000_0000);
    check_eq("basic_w10", wlog[10], 32'h1000_0003);
    check_eq("basic_w11", wlog[11], 32'h0);
    check_eq("basic_w12", wlog[12], 32'h0);
    check_eq("basic_w35", wlog[35], 32'h0);

    // back-pressure mid-row
    load_frame(32'h2000_0000, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      check_eq("bp_wrreq", 32'(wrreq), 32'h0);
    end
    finish_frame("bp", 0, 100);
    check_eq("bp_writes", 32'(wr_actual), 32'(FRAME));
    check_eq("bp_w7", wlog[7], 32'h2000_0000);
    check_eq("bp_w28", wlog[28], 32'h2000_000F);

    // upstream gap after d5
    load_frame(32'h3000_0000, 1'b0);
    for (int n = 0; src_i < 6 && n < 100; n++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    finish_frame("gap", 0, 100);
    check_eq("gap_writes", 32'(wr_actual), 32'(FRAME));
    check_eq("gap_w14", wlog[14], 32'h3000_0005);
    check_eq("gap_w15", wlog[15], 32'h3000_0006);

    // buffer full: downstream stalled, upstream keeps offering
    load_frame(32'h4000_0000, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check_eq("full_accepted", 32'(src_i), 32'h2);
    check_eq("full_in_ready", 32'(in_ready), 32'h0);
    finish_frame("full", 0, 100);
    check_eq("full_writes", 32'(wr_actual), 32'(FRAME));
    check_eq("full_w8", wlog[8], 32'h4000_0001);
    check_eq("full_w9", wlog[9], 32'h4000_0002);

    // reset after write 20
    load_frame(32'h5000_0000, 1'b0);
    for (int n = 0; m_pos != 21 && n < 200; n++) step(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_mid_wrreq", 32'(wrreq), 32'h0);
    check_eq("rst_mid_data", data_out, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    load_frame(32'h6000_0000, 1'b0);
    finish_frame("rst_mid", 0, 100);
    check_eq("rst_mid_writes", 32'(wr_actual), 32'(FRAME));
    for (int i = 0; i < 7; i++) check_eq("rst_mid_lead_zero", wlog[i], 32'h0);
    check_eq("rst_mid_w7", wlog[7], 32'h6000_0000);

    // sign-bit handling on the interior path
    load_frame(32'h0, 1'b1);
    src[0] = 32'hBF80_0000;
    src[1] = 32'h3F80_0000;
    finish_frame("relu", 0, 100);
`ifdef FEATUREMAP_PAD_RELU_EN
    check_eq("relu_w7", wlog[7], 32'h0);
`else
    check_eq("relu_w7", wlog[7], 32'hBF80_0000);
`endif
    check_eq("relu_w8", wlog[8], 32'h3F80_0000);

    // randomized traffic over several frames
    for (int f = 0; f < 4; f++) begin
      load_frame(32'h0, 1'b1);
      finish_frame("random", 25, 70);
      check_eq("random_writes", 32'(wr_actual), 32'(FRAME));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
